// File: rtl/riscv_ex_muldiv_pkg.sv
// riscv_ex_muldiv_pkg
// Shared definitions for the iterative RV32M multiply/divide sequencer.
// It holds the funct3 encodings of the M extension, the sequencer state
// encoding, and helpers that decide which operands are treated as signed.
package riscv_ex_muldiv_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [2:0] FUNCT3_M_MUL    = 3'b000;
    localparam logic [2:0] FUNCT3_M_MULH   = 3'b001;
    localparam logic [2:0] FUNCT3_M_MULHSU = 3'b010;
    localparam logic [2:0] FUNCT3_M_MULHU  = 3'b011;
    localparam logic [2:0] FUNCT3_M_DIV    = 3'b100;
    localparam logic [2:0] FUNCT3_M_DIVU   = 3'b101;
    localparam logic [2:0] FUNCT3_M_REM    = 3'b110;
    localparam logic [2:0] FUNCT3_M_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    // rs1 is signed for every op except the fully unsigned ones
    function automatic logic is_signed_a(input logic [2:0] funct3);
        return !((funct3 == FUNCT3_M_MULHU) || (funct3 == FUNCT3_M_DIVU) ||
                 (funct3 == FUNCT3_M_REMU));
    endfunction

    // rs2 is signed like rs1, except MULHSU treats it as unsigned
    function automatic logic is_signed_b(input logic [2:0] funct3);
        return is_signed_a(funct3) && (funct3 != FUNCT3_M_MULHSU);
    endfunction

    // bit 2 of funct3 separates the divide group from the multiply group
    function automatic logic is_div_op(input logic [2:0] funct3);
        return funct3[2];
    endfunction

endpackage

// File: rtl/riscv_ex_muldiv_negate.sv
// riscv_ex_muldiv_negate
// Conditional two's-complement negation. It produces the operand magnitudes
// before iteration and applies the final sign to the product, quotient or
// remainder.
// Ports:
//   i_value  - value to pass through or negate
//   i_negate - 1 selects -i_value (modulo 2^WIDTH)
//   o_value  - result
module riscv_ex_muldiv_negate #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_value,
    input  logic             i_negate,
    output logic [WIDTH-1:0] o_value
);

    assign o_value = i_negate ? (~i_value + WIDTH'(1)) : i_value;

endmodule

// File: rtl/riscv_ex_muldiv.sv
// riscv_ex_muldiv
// Iterative RV32M multiply/divide sequencer that sits beside the EX-stage ALU.
// It accepts one M instruction and stalls the pipeline for XLEN+1 cycles while
// it iterates. It then presents the result for one cycle, or for longer while
// i_hold is high.
// Ports:
//   i_clk, i_rst        - clock; synchronous active-high reset
//   i_valid, i_funct3   - M instruction present in EX and its operation
//   i_op_a, i_op_b      - forwarded rs1 / rs2 values
//   i_hold              - EX is frozen by another stall source
//   i_flush             - kill the instruction in EX
//   o_stall             - freeze IF/ID/EX while the operation is accepted or iterating
//   o_done              - o_result is valid for the instruction in EX
//   o_result            - registered result
module riscv_ex_muldiv
    import riscv_ex_muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_op_a,
    input  logic [XLEN-1:0] i_op_b,
    input  logic            i_hold,
    input  logic            i_flush,
    output logic            o_stall,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);

    localparam int CNT_W = $clog2(XLEN);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [XLEN-1:0]  abs_a_q, abs_a_d;
    logic [XLEN-1:0]  abs_b_q, abs_b_d;
    logic             neg_a_q, neg_a_d;
    logic             neg_b_q, neg_b_d;
    logic [XLEN-1:0]  hi_q, hi_d;
    logic [XLEN-1:0]  lo_q, lo_d;
    logic [XLEN-1:0]  result_q, result_d;

    // ---------------- operand conditioning at accept time ----------------
    logic            neg_a_in, neg_b_in;
    logic [XLEN-1:0] abs_a_in, abs_b_in;

    assign neg_a_in = is_signed_a(i_funct3) && i_op_a[XLEN-1];
    assign neg_b_in = is_signed_b(i_funct3) && i_op_b[XLEN-1];

    riscv_ex_muldiv_negate #(.WIDTH(XLEN)) u_abs_a (
        .i_value  (i_op_a),
        .i_negate (neg_a_in),
        .o_value  (abs_a_in)
    );

    riscv_ex_muldiv_negate #(.WIDTH(XLEN)) u_abs_b (
        .i_value  (i_op_b),
        .i_negate (neg_b_in),
        .o_value  (abs_b_in)
    );

    // Divide by zero and signed overflow have architecturally fixed results,
    // so they bypass iteration and go straight to DONE.
    logic            div_by_zero, div_ovf, special_case;
    logic [XLEN-1:0] special_result;

    assign div_by_zero  = is_div_op(i_funct3) && (i_op_b == '0);
    assign div_ovf      = ((i_funct3 == FUNCT3_M_DIV) || (i_funct3 == FUNCT3_M_REM)) &&
                          (i_op_a == {1'b1, {(XLEN-1){1'b0}}}) && (i_op_b == '1);
    assign special_case = div_by_zero || div_ovf;

    // funct3[1] separates the remainder ops from the quotient ops
    always_comb begin
        special_result = '0;
        if (div_by_zero) begin
            special_result = i_funct3[1] ? i_op_a : '1;
        end else if (div_ovf) begin
            special_result = i_funct3[1] ? '0 : i_op_a;
        end
    end

    // ---------------- shared per-iteration adder ----------------
    // Multiply: {hi,lo} starts as {0,|b|}. The adder adds |a| into hi when
    // lo[0] is set, then the pair shifts right by one.
    // Divide: hi is the partial remainder and lo starts as |a|. The adder
    // subtracts |b| from {hi,lo[msb]}; a non-negative difference is kept and
    // a 1 is shifted into the quotient.
    logic            is_mul_q;
    logic [XLEN:0]   add_x, add_y, add_sum;
    logic            add_cin;
    logic [XLEN-1:0] iter_hi, iter_lo;

    assign is_mul_q = !is_div_op(funct3_q);

    always_comb begin
        add_x   = {1'b0, hi_q};
        add_y   = '0;
        add_cin = 1'b0;
        if (is_mul_q) begin
            add_y = lo_q[0] ? {1'b0, abs_a_q} : '0;
        end else begin
            add_x   = {hi_q, lo_q[XLEN-1]};
            add_y   = ~{1'b0, abs_b_q};
            add_cin = 1'b1;
        end
    end

    assign add_sum = add_x + add_y + {{XLEN{1'b0}}, add_cin};

    always_comb begin
        iter_hi = hi_q;
        iter_lo = lo_q;
        if (is_mul_q) begin
            iter_hi = add_sum[XLEN:1];
            iter_lo = {add_sum[0], lo_q[XLEN-1:1]};
        end else if (!add_sum[XLEN]) begin
            iter_hi = add_sum[XLEN-1:0];
            iter_lo = {lo_q[XLEN-2:0], 1'b1};
        end else begin
            iter_hi = add_x[XLEN-1:0];
            iter_lo = {lo_q[XLEN-2:0], 1'b0};
        end
    end

    // ---------------- sign fix-up of the final iteration ----------------
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   div_raw, div_fix;
    logic              div_neg;
    logic [XLEN-1:0]   final_result;

    riscv_ex_muldiv_negate #(.WIDTH(2*XLEN)) u_fix_prod (
        .i_value  ({iter_hi, iter_lo}),
        .i_negate (neg_a_q ^ neg_b_q),
        .o_value  (prod_fix)
    );

    // The remainder follows the dividend's sign; the quotient is negated
    // when the operand signs differ.
    assign div_raw = funct3_q[1] ? iter_hi : iter_lo;
    assign div_neg = funct3_q[1] ? neg_a_q : (neg_a_q ^ neg_b_q);

    riscv_ex_muldiv_negate #(.WIDTH(XLEN)) u_fix_div (
        .i_value  (div_raw),
        .i_negate (div_neg),
        .o_value  (div_fix)
    );

    always_comb begin
        final_result = div_fix;
        if (is_mul_q) begin
            final_result = (funct3_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0]
                                                    : prod_fix[2*XLEN-1:XLEN];
        end
    end

    logic last_iter;
    assign last_iter = (count_q == CNT_W'(XLEN-1));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= MD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            MD_IDLE: if (i_valid) state_d = special_case ? MD_DONE : MD_BUSY;
            MD_BUSY: if (last_iter) state_d = MD_DONE;
            MD_DONE: if (!i_hold) state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
        if (i_flush) begin
            state_d = MD_IDLE;
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        o_stall = 1'b0;
        o_done  = 1'b0;
        if (!i_rst && !i_flush) begin
            o_stall = ((state_q == MD_IDLE) && i_valid) || (state_q == MD_BUSY);
            o_done  = (state_q == MD_DONE);
        end
    end

    assign o_result = result_q;

    // ---------------- datapath next-state ----------------
    always_comb begin
        count_d  = count_q;
        funct3_d = funct3_q;
        abs_a_d  = abs_a_q;
        abs_b_d  = abs_b_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        result_d = result_q;
        case (state_q)
            MD_IDLE: begin
                if (i_valid && !i_flush) begin
                    funct3_d = i_funct3;
                    abs_a_d  = abs_a_in;
                    abs_b_d  = abs_b_in;
                    neg_a_d  = neg_a_in;
                    neg_b_d  = neg_b_in;
                    count_d  = '0;
                    hi_d     = '0;
                    lo_d     = is_div_op(i_funct3) ? abs_a_in : abs_b_in;
                    if (special_case) begin
                        result_d = special_result;
                    end
                end
            end
            MD_BUSY: begin
                if (!i_flush) begin
                    hi_d    = iter_hi;
                    lo_d    = iter_lo;
                    count_d = count_q + CNT_W'(1);
                    if (last_iter) begin
                        result_d = final_result;
                    end
                end
            end
            default: ;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q  <= '0;
            funct3_q <= '0;
            abs_a_q  <= '0;
            abs_b_q  <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
        end else begin
            count_q  <= count_d;
            funct3_q <= funct3_d;
            abs_a_q  <= abs_a_d;
            abs_b_q  <= abs_b_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            result_q <= result_d;
        end
    end

endmodule
